io_scan_ctrl: RTL and testbench

IO_SCAN_CTRL -- requirements
Module: io_scan_ctrl

---
 rtl/io_scan_pkg.sv | 21 ++
 rtl/io_scan_sync.sv | 28 ++
 rtl/io_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_io_scan_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/io_scan_pkg.sv
// Shared types and defaults for the LED/pad release-and-sense scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package io_scan_pkg;

    typedef enum logic [1:0] {
        ST_DRIVE   = 2'd0,
        ST_RELEASE = 2'd1,
        ST_SAMPLE  = 2'd2
    } scan_state_t;

    localparam int DEF_N_PINS        = 4;
    localparam int DEF_DRIVE_CYCLES  = 1024;
    localparam int DEF_SETTLE_CYCLES = 4;

    // Larger of two phase lengths; sizes the shared phase counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/io_scan_sync.sv
// Two-stage synchronizer bringing the asynchronous pad inputs into clk.
// Latency: 2 clocks from a stable pad level to dout.
// Backpressure: none; free-running.
module io_scan_sync
    import io_scan_pkg::*;
#(
    parameter int WIDTH = DEF_N_PINS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a full clock to resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/io_scan_ctrl.sv
// Drives an LED pattern on shared pads, periodically releases them and senses their level.
// Latency: sense result 1 clock after SAMPLE; new pattern on pads 1 clock after it is taken in DRIVE.
// Backpressure: pat_ready low while one pattern is pending; optional IO_SCAN_DEBOUNCE_EN filters sense.
module io_scan_ctrl
    import io_scan_pkg::*;
#(
    parameter int N_PINS        = DEF_N_PINS,
    parameter int DRIVE_CYCLES  = DEF_DRIVE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic              pat_valid,
    input  logic [N_PINS-1:0] pat_data,
    output logic              pat_ready,
    output logic [N_PINS-1:0] pin_oe,
    output logic [N_PINS-1:0] pin_dout,
    input  logic [N_PINS-1:0] pin_din,
    output logic              sense_valid,
    output logic [N_PINS-1:0] sense_data
);

    localparam int              CNT_W       = $clog2(max2(DRIVE_CYCLES, SETTLE_CYCLES));
    localparam logic [CNT_W-1:0] DRIVE_LAST  = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    scan_state_t       state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              run;
    logic              pend_flag, pend_flag_next;
    logic [N_PINS-1:0] pend_dat;
    logic [N_PINS-1:0] active;
    logic [N_PINS-1:0] din_sync;
    logic [N_PINS-1:0] oe_d, dout_d;
    logic              xfer;
    logic              accept;

    io_scan_sync #(.WIDTH(N_PINS)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (pin_din),
        .dout (din_sync)
    );

    // State register; run holds the phase counter for the first clock out of
    // reset so the opening DRIVE phase is a full DRIVE_CYCLES long on the pads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_DRIVE;
            cnt   <= '0;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            run   <= 1'b1;
        end
    end

    // Phase sequencing; counter always restarts at 0 on a phase change so the period never drifts.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (run) begin
            case (state)
                ST_DRIVE: begin
                    if (!scan_en) begin
                        cnt_next = '0;
                    end else if (cnt == DRIVE_LAST) begin
                        state_next = ST_RELEASE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == SETTLE_LAST) begin
                        state_next = ST_SAMPLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    state_next = ST_DRIVE;
                    cnt_next   = '0;
                end
                default: begin
                    state_next = ST_DRIVE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Pad drive for the coming cycle; a still-pending pattern is shown directly so a
    // pattern taken while released appears on the very first DRIVE clock.
    always_comb begin
        oe_d   = '0;
        dout_d = '0;
        if (state_next == ST_DRIVE) begin
            oe_d   = '1;
            dout_d = pend_flag ? pend_dat : active;
        end
    end

    // Registered pad outputs keep the pads glitch-free and quiet during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_oe   <= '0;
            pin_dout <= '0;
        end else begin
            pin_oe   <= oe_d;
            pin_dout <= dout_d;
        end
    end

    assign xfer           = pat_valid & pat_ready;
    assign pend_flag_next = xfer | (pend_flag & (state != ST_DRIVE));

    // One-deep pattern buffer: accept into pending, promote to active on every DRIVE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_flag <= 1'b0;
            pend_dat  <= '0;
            active    <= '0;
            pat_ready <= 1'b0;
        end else begin
            if (xfer) begin
                pend_dat <= pat_data;
            end
            if (state == ST_DRIVE) begin
                active <= pend_dat;
            end
            pend_flag <= pend_flag_next;
            pat_ready <= ~pend_flag_next;
        end
    end

`ifdef IO_SCAN_DEBOUNCE_EN
    logic [N_PINS-1:0] prev_raw;

    assign accept = (din_sync == prev_raw);

    // Remember the last raw sample; a result is only reported once two scans agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_raw <= '0;
        end else if (state == ST_SAMPLE) begin
            prev_raw <= din_sync;
        end
    end
`else
    assign accept = 1'b1;
`endif

    // Capture the synchronized pad level at SAMPLE and flag it for one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sense_valid <= 1'b0;
            sense_data  <= '0;
        end else begin
            sense_valid <= (state == ST_SAMPLE) && accept;
            if ((state == ST_SAMPLE) && accept) begin
                sense_data <= din_sync;
            end
        end
    end

endmodule

// File: tb/tb_io_scan_ctrl.sv
// Directed bench for io_scan_ctrl with N_PINS=4, DRIVE_CYCLES=8, SETTLE_CYCLES=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_io_scan_ctrl;

`ifdef IO_SCAN_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_en;
    logic       pat_valid;
    logic [3:0] pat_data;
    logic       pat_ready;
    logic [3:0] pin_oe;
    logic [3:0] pin_dout;
    logic [3:0] pin_din;
    logic       sense_valid;
    logic [3:0] sense_data;

    int vectors     = 0;
    int miscompares = 0;

    io_scan_ctrl #(
        .N_PINS        (4),
        .DRIVE_CYCLES  (8),
        .SETTLE_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_en     (scan_en),
        .pat_valid   (pat_valid),
        .pat_data    (pat_data),
        .pat_ready   (pat_ready),
        .pin_oe      (pin_oe),
        .pin_dout    (pin_dout),
        .pin_din     (pin_din),
        .sense_valid (sense_valid),
        .sense_data  (sense_data)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] din_tbl [3];
        din_tbl[0] = 4'h1;
        din_tbl[1] = 4'h2;
        din_tbl[2] = 4'h2;

        rst       = 1'b1;
        scan_en   = 1'b1;
        pat_valid = 1'b0;
        pat_data  = 4'h0;
        pin_din   = 4'hA;

        // Reset values while rst is held
        #2;
        check("rst_oe",    32'(pin_oe),      32'h0);
        check("rst_dout",  32'(pin_dout),    32'h0);
        check("rst_sv",    32'(sense_valid), 32'h0);
        check("rst_sd",    32'(sense_data),  32'h0);
        check("rst_ready", 32'(pat_ready),   32'h0);

        // Free-running scan: 8 DRIVE, 3 RELEASE, 1 SAMPLE, pulse on the clock after SAMPLE
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 26; k++) begin
            step(1);
            check($sformatf("scan_oe_k%0d", k), 32'(pin_oe), ((k % 12) < 8) ? 32'hF : 32'h0);
            check($sformatf("scan_dout_k%0d", k), 32'(pin_dout), 32'h0);
            check($sformatf("scan_sv_k%0d", k), 32'(sense_valid),
                  ((k == 24) || (!DEB && k == 12)) ? 32'h1 : 32'h0);
            if (k == 0) check("first_ready", 32'(pat_ready), 32'h1);
            if (k == 24) check("scan_sd", 32'(sense_data), 32'hA);
        end

        // Pattern 5 taken mid-DRIVE (k=26); a second offer the next clock is refused
        pat_valid = 1'b1;
        pat_data  = 4'h5;
        step(1);
        check("drv_ready_low", 32'(pat_ready), 32'h0);
        pat_data = 4'h9;
        step(1);
        check("drv_ready_back", 32'(pat_ready), 32'h1);
        pat_valid = 1'b0;
        step(1);
        check("drv_dout5", 32'(pin_dout), 32'h5);
        check("drv_oe",    32'(pin_oe),   32'hF);

        // Pattern 3 taken during RELEASE (k=32..34): shown from the first DRIVE clock (k=36)
        step(4);
        check("rel_oe", 32'(pin_oe), 32'h0);
        pat_valid = 1'b1;
        pat_data  = 4'h3;
        step(1);
        check("rel_ready_low", 32'(pat_ready), 32'h0);
        check("rel_dout_k33",  32'(pin_dout),  32'h0);
        pat_valid = 1'b0;
        step(1);
        check("rel_dout_k34", 32'(pin_dout), 32'h0);
        step(1);
        check("smp_dout_k35", 32'(pin_dout), 32'h0);
        check("smp_oe_k35",   32'(pin_oe),   32'h0);
        step(1);
        check("rel_dout_k36", 32'(pin_dout),    32'h3);
        check("rel_oe_k36",   32'(pin_oe),      32'hF);
        check("rel_sv_k36",   32'(sense_valid), 32'h1);
        check("rel_sd_k36",   32'(sense_data),  32'hA);
        step(1);
        check("rel_dout_k37",  32'(pin_dout),  32'h3);
        check("rel_ready_k37", 32'(pat_ready), 32'h1);

        // Reset pulsed mid-RELEASE (k=45): no sense pulse, then a clean restart
        step(8);
        check("mid_rel_oe", 32'(pin_oe), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_oe",    32'(pin_oe),      32'h0);
        check("arst_dout",  32'(pin_dout),    32'h0);
        check("arst_sv",    32'(sense_valid), 32'h0);
        check("arst_ready", 32'(pat_ready),   32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check($sformatf("hold_sv_%0d", i), 32'(sense_valid), 32'h0);
            check($sformatf("hold_oe_%0d", i), 32'(pin_oe),      32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 13; k++) begin
            step(1);
            check($sformatf("rs_oe_k%0d", k), 32'(pin_oe), ((k % 12) < 8) ? 32'hF : 32'h0);
            check($sformatf("rs_sv_k%0d", k), 32'(sense_valid),
                  (!DEB && k == 12) ? 32'h1 : 32'h0);
            if (k == 0) begin
                check("rs_dout", 32'(pin_dout),  32'h0);
                check("rs_ready", 32'(pat_ready), 32'h1);
            end
        end

        // Three scans with pad levels 1, 2, 2 (only the last agrees with its predecessor)
        for (int s = 0; s < 3; s++) begin
            pin_din = din_tbl[s];
            for (int c = 1; c <= 12; c++) begin
                step(1);
                check($sformatf("deb_sv_s%0d_c%0d", s, c), 32'(sense_valid),
                      ((c == 12) && (!DEB || s == 2)) ? 32'h1 : 32'h0);
                if ((c == 12) && (!DEB || s == 2))
                    check($sformatf("deb_sd_s%0d", s), 32'(sense_data), 32'(din_tbl[s]));
            end
        end

        // scan_en dropped mid-RELEASE: the scan completes, then DRIVE holds
        step(8);
        scan_en = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            step(1);
            check($sformatf("stop_oe_c%0d", c), 32'(pin_oe), (c <= 3) ? 32'h0 : 32'hF);
            check($sformatf("stop_sv_c%0d", c), 32'(sense_valid), (c == 4) ? 32'h1 : 32'h0);
            if (c == 4) check("stop_sd", 32'(sense_data), 32'h2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
